// File: rtl/alu.sv
// RV32I integer ALU with branch/jump resolution; optional M-extension multiplier under `ALU_MUL_EN.
// Latency: 1 cycle for base ops (registered result strobe); 4 cycles accept-to-strobe for MUL* when enabled.
// Backpressure: rdy=0 freezes everything; alu_busy (multiplier only, else constant 0) holds off dispatch.
`ifndef OP_WID
`define OP_WID 7
`endif
`ifndef FUNCT3_WID
`define FUNCT3_WID 3
`endif
`ifndef ROB_POS_WID
`define ROB_POS_WID 4
`endif
`ifndef OP_R_TYPE
`define OP_R_TYPE 7'b0110011
`define OP_I_TYPE 7'b0010011
`define OP_LUI    7'b0110111
`define OP_AUIPC  7'b0010111
`define OP_JAL    7'b1101111
`define OP_JALR   7'b1100111
`define OP_BRANCH 7'b1100011
`endif

module alu (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    rollback,
    input  logic                    alu_en,
    input  logic [31:0]             alu_val1,
    input  logic [31:0]             alu_val2,
    input  logic [31:0]             alu_imm,
    input  logic [31:0]             alu_pc,
    input  logic [`OP_WID-1:0]      alu_opcode,
    input  logic [`FUNCT3_WID-1:0]  alu_funct3,
    input  logic                    alu_funct7,
    input  logic                    alu_mul,
    input  logic [`ROB_POS_WID-1:0] alu_rob_pos,
    output logic                    alu_busy,
    output logic                    result,
    output logic [31:0]             result_val,
    output logic [`ROB_POS_WID-1:0] result_rob_pos,
    output logic                    result_jump,
    output logic [31:0]             result_pc
);
    logic        is_r;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] pc4;
    logic [31:0] calc_val;
    logic [31:0] calc_pc;
    logic        calc_jump;
    logic        take;
    logic        accept_alu;

    always_comb begin
        is_r      = (alu_opcode == `OP_R_TYPE);
        op2       = is_r ? alu_val2 : alu_imm;
        shamt     = op2[4:0];
        pc4       = alu_pc + 32'd4;
        calc_val  = '0;
        calc_pc   = pc4;
        calc_jump = 1'b0;
        take      = 1'b0;
        case (alu_opcode)
            `OP_R_TYPE, `OP_I_TYPE: begin
                case (alu_funct3)
                    3'd0:    calc_val = (alu_funct7 && is_r) ? alu_val1 - op2 : alu_val1 + op2;
                    3'd1:    calc_val = alu_val1 << shamt;
                    3'd2:    calc_val = {31'd0, $signed(alu_val1) < $signed(op2)};
                    3'd3:    calc_val = {31'd0, alu_val1 < op2};
                    3'd4:    calc_val = alu_val1 ^ op2;
                    3'd5:    calc_val = alu_funct7 ? 32'($signed(alu_val1) >>> shamt) : alu_val1 >> shamt;
                    3'd6:    calc_val = alu_val1 | op2;
                    default: calc_val = alu_val1 & op2;
                endcase
`ifdef ALU_MUL_EN
                // Divide encodings have no divider behind them: single-cycle zero.
                if (is_r && alu_mul && alu_funct3[2])
                    calc_val = '0;
`endif
            end
            `OP_LUI:   calc_val = alu_imm;
            `OP_AUIPC: calc_val = alu_pc + alu_imm;
            `OP_JAL: begin
                calc_val  = pc4;
                calc_jump = 1'b1;
                calc_pc   = alu_pc + alu_imm;
            end
            `OP_JALR: begin
                calc_val  = pc4;
                calc_jump = 1'b1;
                calc_pc   = (alu_val1 + alu_imm) & ~32'd1;
            end
            `OP_BRANCH: begin
                case (alu_funct3)
                    3'd0:    take = (alu_val1 == alu_val2);
                    3'd1:    take = (alu_val1 != alu_val2);
                    3'd4:    take = ($signed(alu_val1) < $signed(alu_val2));
                    3'd5:    take = ($signed(alu_val1) >= $signed(alu_val2));
                    3'd6:    take = (alu_val1 < alu_val2);
                    3'd7:    take = (alu_val1 >= alu_val2);
                    default: take = 1'b0;
                endcase
                calc_jump = take;
                calc_pc   = take ? alu_pc + alu_imm : pc4;
            end
            default: ;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    is_mul;
    logic                    mul_fire;
    logic [1:0]              cnt;
    logic [31:0]             m_a;
    logic [31:0]             m_b;
    logic [1:0]              m_f3;
    logic [31:0]             m_pc;
    logic [`ROB_POS_WID-1:0] m_rob;
    logic signed [32:0]      mul_a;
    logic signed [32:0]      mul_b;
    logic signed [65:0]      mul_prod;
    logic [31:0]             mul_val;
    logic                    unused_prod;

    assign is_mul     = is_r && alu_mul && !alu_funct3[2];
    assign accept_alu = alu_en && !rollback && (state == IDLE) && !is_mul;
    assign mul_fire   = (state == DONE) && !rollback;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else if (rdy)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (alu_en && is_mul) state_nxt = MUL;
            MUL:     if (cnt == 2'd1) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (rollback)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            m_a      <= '0;
            m_b      <= '0;
            m_f3     <= '0;
            m_pc     <= '0;
            m_rob    <= '0;
            alu_busy <= 1'b0;
        end else if (rdy) begin
            if (state == IDLE && state_nxt == MUL) begin
                cnt   <= '0;
                m_a   <= alu_val1;
                m_b   <= alu_val2;
                m_f3  <= alu_funct3[1:0];
                m_pc  <= alu_pc;
                m_rob <= alu_rob_pos;
            end else if (state == MUL) begin
                cnt <= cnt + 2'd1;
            end
            // Busy spans the strobe cycle so no dispatch lands on the DONE->IDLE edge.
            alu_busy <= (state_nxt != IDLE) || mul_fire;
        end
    end

    // funct3[1:0]: 0 MUL, 1 MULH (s*s), 2 MULHSU (s*u), 3 MULHU (u*u).
    assign mul_a       = {(m_f3 != 2'd3) & m_a[31], m_a};
    assign mul_b       = {(m_f3 == 2'd1) & m_b[31], m_b};
    assign mul_prod    = mul_a * mul_b;
    assign mul_val     = (m_f3 == 2'd0) ? mul_prod[31:0] : mul_prod[63:32];
    assign unused_prod = ^mul_prod[65:64];
`else
    logic unused_mul;

    assign accept_alu = alu_en && !rollback;
    assign alu_busy   = 1'b0;
    assign unused_mul = alu_mul;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result         <= 1'b0;
            result_val     <= '0;
            result_rob_pos <= '0;
            result_jump    <= 1'b0;
            result_pc      <= '0;
        end else if (rdy) begin
            result <= accept_alu;
            if (accept_alu) begin
                result_val     <= calc_val;
                result_rob_pos <= alu_rob_pos;
                result_jump    <= calc_jump;
                result_pc      <= calc_pc;
            end
`ifdef ALU_MUL_EN
            else if (mul_fire) begin
                result         <= 1'b1;
                result_val     <= mul_val;
                result_rob_pos <= m_rob;
                result_jump    <= 1'b0;
                result_pc      <= m_pc + 32'd4;
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (default build): directed cases plus randomized ops vs a behavioural model.
`ifndef OP_WID
`define OP_WID 7
`endif
`ifndef FUNCT3_WID
`define FUNCT3_WID 3
`endif
`ifndef ROB_POS_WID
`define ROB_POS_WID 4
`endif
`ifndef OP_R_TYPE
`define OP_R_TYPE 7'b0110011
`define OP_I_TYPE 7'b0010011
`define OP_LUI    7'b0110111
`define OP_AUIPC  7'b0010111
`define OP_JAL    7'b1101111
`define OP_JALR   7'b1100111
`define OP_BRANCH 7'b1100011
`endif

module tb_alu;
    logic                    clk;
    logic                    rst;
    logic                    rdy;
    logic                    rollback;
    logic                    alu_en;
    logic [31:0]             alu_val1;
    logic [31:0]             alu_val2;
    logic [31:0]             alu_imm;
    logic [31:0]             alu_pc;
    logic [`OP_WID-1:0]      alu_opcode;
    logic [`FUNCT3_WID-1:0]  alu_funct3;
    logic                    alu_funct7;
    logic                    alu_mul;
    logic [`ROB_POS_WID-1:0] alu_rob_pos;
    logic                    alu_busy;
    logic                    result;
    logic [31:0]             result_val;
    logic [`ROB_POS_WID-1:0] result_rob_pos;
    logic                    result_jump;
    logic [31:0]             result_pc;

    alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_pc(alu_pc),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_mul(alu_mul), .alu_rob_pos(alu_rob_pos), .alu_busy(alu_busy),
        .result(result), .result_val(result_val), .result_rob_pos(result_rob_pos),
        .result_jump(result_jump), .result_pc(result_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } exp_t;

    int checks = 0;
    int failures = 0;

    logic        e_res;
    logic [31:0] e_val;
    logic [31:0] e_rob;
    logic        e_jump;
    logic [31:0] e_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".result"}, {31'd0, result}, {31'd0, e_res});
        check({tag, ".val"}, result_val, e_val);
        check({tag, ".rob"}, {28'd0, result_rob_pos}, e_rob);
        check({tag, ".jump"}, {31'd0, result_jump}, {31'd0, e_jump});
        check({tag, ".pc"}, result_pc, e_pc);
        check({tag, ".busy"}, {31'd0, alu_busy}, 32'd0);
    endtask

    // Reference semantics written straight from the RV32I instruction definitions.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] o2;
        longint      sa, sb, ua, ub;
        bit          t;
        e.val  = 32'd0;
        e.jump = 1'b0;
        e.pc   = pc + 32'd4;
        o2 = (op == `OP_R_TYPE) ? b : imm;
        if (op == `OP_R_TYPE || op == `OP_I_TYPE) begin
            sa = longint'($signed(a)); sb = longint'($signed(o2));
            ua = longint'(a);          ub = longint'(o2);
            case (f3)
                3'd0: e.val = (op == `OP_R_TYPE && f7) ? 32'(ua - ub) : 32'(ua + ub);
                3'd1: e.val = 32'(ua * (longint'(1) << o2[4:0]));
                3'd2: e.val = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: e.val = (ua < ub) ? 32'd1 : 32'd0;
                3'd4: e.val = a ^ o2;
                3'd5: e.val = f7 ? 32'(sa / (longint'(1) << o2[4:0]) - ((sa < 0 && (sa % (longint'(1) << o2[4:0])) != 0) ? 1 : 0))
                                 : 32'(ua / (longint'(1) << o2[4:0]));
                3'd6: e.val = a | o2;
                default: e.val = a & o2;
            endcase
        end else if (op == `OP_LUI) begin
            e.val = imm;
        end else if (op == `OP_AUIPC) begin
            e.val = pc + imm;
        end else if (op == `OP_JAL) begin
            e.val = pc + 32'd4; e.jump = 1'b1; e.pc = pc + imm;
        end else if (op == `OP_JALR) begin
            e.val = pc + 32'd4; e.jump = 1'b1; e.pc = (a + imm) & 32'hFFFF_FFFE;
        end else if (op == `OP_BRANCH) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            ua = longint'(a);          ub = longint'(b);
            case (f3)
                3'd0: t = (ua == ub);
                3'd1: t = (ua != ub);
                3'd4: t = (sa < sb);
                3'd5: t = (sa >= sb);
                3'd6: t = (ua < ub);
                3'd7: t = (ua >= ub);
                default: t = 1'b0;
            endcase
            e.jump = t;
            if (t) e.pc = pc + imm;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [3:0] rob);
        alu_en = 1'b1; alu_opcode = op; alu_funct3 = f3; alu_funct7 = f7;
        alu_val1 = a; alu_val2 = b; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
    endtask

    task automatic expect_res(input logic [31:0] val, input logic jump, input logic [31:0] pc,
                              input logic [3:0] rob);
        e_res = 1'b1; e_val = val; e_jump = jump; e_pc = pc; e_rob = {28'd0, rob};
    endtask

    logic [6:0] ops [8];
    exp_t       m;

    initial begin
        ops = '{`OP_R_TYPE, `OP_I_TYPE, `OP_LUI, `OP_AUIPC, `OP_JAL, `OP_JALR, `OP_BRANCH, 7'b1111111};
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0; alu_mul = 1'b0;
        alu_val1 = '0; alu_val2 = '0; alu_imm = '0; alu_pc = '0;
        alu_opcode = '0; alu_funct3 = '0; alu_funct7 = 1'b0; alu_rob_pos = '0;
        e_res = 1'b0; e_val = '0; e_rob = '0; e_jump = 1'b0; e_pc = '0;
        #1;
        check_all("reset");
        tick(); tick();
        rst = 1'b1;
        tick();
        check_all("idle");

        issue(`OP_R_TYPE, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h200, 4'd3);
        tick(); expect_res(32'd0, 1'b0, 32'h204, 4'd3); check_all("add_wrap");
        issue(`OP_R_TYPE, 3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'h10, 4'd1);
        tick(); expect_res(32'hF800_0000, 1'b0, 32'h14, 4'd1); check_all("sra");
        issue(`OP_R_TYPE, 3'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h20, 4'd2);
        tick(); expect_res(32'd1, 1'b0, 32'h24, 4'd2); check_all("sltu");
        issue(`OP_BRANCH, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd4);
        tick(); expect_res(32'd0, 1'b1, 32'h120, 4'd4); check_all("blt");
        issue(`OP_BRANCH, 3'd7, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 4'd5);
        tick(); expect_res(32'd0, 1'b1, 32'h120, 4'd5); check_all("bgeu");
        issue(`OP_BRANCH, 3'd0, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd6);
        tick(); expect_res(32'd0, 1'b0, 32'h104, 4'd6); check_all("beq");
        issue(`OP_JALR, 3'd0, 1'b0, 32'h1003, 32'd0, 32'd0, 32'h40, 4'd7);
        tick(); expect_res(32'h44, 1'b1, 32'h1002, 4'd7); check_all("jalr");
        issue(7'b1111111, 3'd0, 1'b0, 32'd9, 32'd9, 32'd9, 32'h80, 4'd8);
        tick(); expect_res(32'd0, 1'b0, 32'h84, 4'd8); check_all("unknown");
        alu_en = 1'b0;
        tick(); e_res = 1'b0; check_all("strobe_drop");

        // rdy low right after dispatch: strobe and value freeze, no re-pulse afterwards.
        issue(`OP_R_TYPE, 3'd0, 1'b0, 32'd5, 32'd6, 32'd0, 32'h300, 4'd9);
        tick(); expect_res(32'd11, 1'b0, 32'h304, 4'd9); check_all("rdy_pre");
        rdy = 1'b0;
        issue(`OP_R_TYPE, 3'd0, 1'b1, 32'd50, 32'd6, 32'd0, 32'h400, 4'd1);
        tick(); check_all("rdy_hold1");
        tick(); check_all("rdy_hold2");
        rdy = 1'b1; alu_en = 1'b0;
        tick(); e_res = 1'b0; check_all("rdy_release");

        issue(`OP_R_TYPE, 3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'h500, 4'd2);
        rollback = 1'b1;
        tick(); check_all("rollback");
        rollback = 1'b0; alu_en = 1'b0;

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        issue(`OP_LUI, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'h600, 4'd3);
        tick(); expect_res(32'h1234_5000, 1'b0, 32'h604, 4'd3); check_all("lui");
        alu_en = 1'b0;
        #2 rst = 1'b0;
        #1 e_res = 1'b0; e_val = '0; e_rob = '0; e_jump = 1'b0; e_pc = '0;
        check_all("async_rst");
        tick();
        rst = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            logic        en, rb;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {27'd0, b[4:0]};
            issue(ops[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  a, b, $urandom, $urandom & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)));
`ifdef ALU_MUL_EN
            alu_mul = 1'b0;
`else
            alu_mul = 1'($urandom_range(0, 1));
`endif
            en = ($urandom_range(0, 7) != 0);
            rb = ($urandom_range(0, 9) == 0);
            alu_en = en; rollback = rb;
            m = model(alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2, alu_imm, alu_pc);
            if (en && !rb) begin
                expect_res(m.val, m.jump, m.pc, alu_rob_pos);
            end else begin
                e_res = 1'b0;
            end
            tick();
            check_all("rand");
        end
        rollback = 1'b0; alu_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, regardless of clk.
REQ-003 rdy  input  1  global enable; 0 freezes all internal state and outputs.
REQ-004 rollback  input  1  misprediction flush.
REQ-005 alu_en  input  1  operation dispatch strobe from RS.
REQ-006 alu_val1, alu_val2, alu_imm, alu_pc  input  32 each  operand 1, operand 2, sign-extended immediate, instruction PC.
REQ-007 alu_opcode  input  `OP_WID  RV32I opcode.
REQ-008 alu_funct3  input  `FUNCT3_WID  funct3.
REQ-009 alu_funct7  input  1  instruction bit 30 (SUB/SRA select).
REQ-010 alu_mul  input  1  instruction bit 25 (M-extension select); ignored unless ALU_MUL_EN is defined.
REQ-011 alu_rob_pos  input  `ROB_POS_WID  destination ROB entry.
REQ-012 alu_busy  output  1  1 = dispatch not accepted next cycle; RS holds off alu_en.
REQ-013 result  output  1  one-cycle result broadcast strobe to RS, LSB, ROB.
REQ-014 result_val  output  32  value written to rd.
REQ-015 result_rob_pos  output  `ROB_POS_WID  ROB tag of result.
REQ-016 result_jump  output  1  1 = control transfer taken.
REQ-017 result_pc  output  32  resolved next PC.

Function
REQ-018 Single-cycle ops: alu_en sampled at edge N; result=1 for exactly the cycle after edge N, then 0.
REQ-019 Operand 2: alu_val2 for `OP_R_TYPE, alu_imm for `OP_I_TYPE; shift amount is operand2[4:0]; SRA/SRAI, SUB when alu_funct7=1 (SUB only for R-type).
REQ-020 ADD/SUB/AND/OR/XOR wrap modulo 2^32; SLT signed, SLTU unsigned, result 0 or 1.
REQ-021 LUI: val=imm; AUIPC: val=pc+imm; jump=0, result_pc=pc+4 for all non-control ops.
REQ-022 JAL: val=pc+4, jump=1, result_pc=pc+imm. JALR: val=pc+4, jump=1, result_pc=(val1+imm)&~1.
REQ-023 Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU by funct3): val=0; taken -> jump=1, result_pc=pc+imm; not taken -> jump=0, result_pc=pc+4.
REQ-024 Unknown opcode: result strobe still issued, val=0, jump=0, result_pc=pc+4.
REQ-025 Without ALU_MUL_EN, alu_busy is constantly 0; one op accepted per cycle, back-to-back.
REQ-026 rollback=1 at an edge: result driven 0 next cycle; in-flight operation discarded; alu_en ignored in that cycle.
REQ-027 rdy=0: no input sampled, all outputs hold their values (result held, not re-pulsed when rdy returns).

Reset
REQ-028 rst=0: result=0, result_jump=0, alu_busy=0, result_val=0, result_pc=0, result_rob_pos=0, FSM=IDLE.
REQ-029 Reset mid-multiply aborts it with no result strobe.

Configuration
REQ-030 Macro ALU_MUL_EN: defined -> MUL/MULH/MULHSU/MULHU (R-type, alu_mul=1, funct3[2]=0) execute in a 3-state FSM IDLE->MUL->DONE with counter; latency 4 cycles from accept edge to result strobe; alu_busy=1 from cycle after accept through cycle of result strobe; alu_en while busy is a protocol error, ignored.
REQ-031 ALU_MUL_EN: MUL low 32 bits; MULH signed x signed high; MULHSU signed x unsigned high; MULHU unsigned high. R-type with alu_mul=1, funct3[2]=1 (divide) -> single-cycle, val=0.
REQ-032 Not defined -> alu_mul ignored; such instructions decode as base R-type ops; no FSM logic synthesised.

Verification
REQ-033 ADD val1=0xFFFFFFFF val2=1 rob_pos=3 -> next cycle result=1, val=0, rob_pos=3, jump=0, result_pc=pc+4.
REQ-034 SRA R-type val1=0x80000000 val2=4 funct7=1 -> val=0xF8000000; SLTU val1=1 val2=0xFFFFFFFF -> val=1.
REQ-035 BLT pc=0x100 imm=0x20 val1=-1 val2=0 -> jump=1, result_pc=0x120; BGEU same operands -> jump=1; BEQ val1=1 val2=2 -> jump=0, result_pc=0x104.
REQ-036 JALR pc=0x40 val1=0x1003 imm=0 -> val=0x44, jump=1, result_pc=0x1002.
REQ-037 ALU_MUL_EN: MULH val1=0x80000000 val2=2 -> alu_busy for 4 cycles, result on 4th cycle after accept, val=0xFFFFFFFF; rollback during MUL -> no result, alu_busy=0 next cycle.
REQ-038 rdy=0 on the cycle after an ADD dispatch -> result held at 1 with same val until rdy=1, then deasserts after one more cycle.
